// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Define MULDIV_RADIX4_EN to retire two bits per CALC cycle instead of one.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            keep,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

`ifdef MULDIV_RADIX4_EN
  localparam int unsigned Iter = 16;
`else
  localparam int unsigned Iter = 32;
`endif
  localparam logic [4:0] IterM1 = 5'(Iter - 1);

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Shift-add step: acc = {partial high, remaining multiplier bits}.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   a);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a} : {(XLEN+1){1'b0}});
    return {sum, acc[XLEN-1:1]};
  endfunction

  // Restoring step: acc = {remainder, dividend bits shifting into quotient}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   d);
    logic [XLEN:0] sh, diff;
    sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = sh - {1'b0, d};
    if (!diff[XLEN]) return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    return {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  endfunction

  logic            rs1_signed, rs2_signed, s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    rs1_signed  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    rs2_signed  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    s1          = rs1_signed & rs1[XLEN-1];
    s2          = rs2_signed & rs2[XLEN-1];
    mag1        = s1 ? -rs1 : rs1;
    mag2        = s2 ? -rs2 : rs2;
    div_zero    = op[2] && (rs2 == '0);
    div_ovf     = op[2] && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    // Overflow quotient equals rs1 itself (the most negative value).
    special_res = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
  end

  logic [2*XLEN-1:0] step1, acc_nxt, prod;
  logic [XLEN-1:0]   div_sel, fix_res;

  always_comb begin
    step1 = op_q[2] ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
`ifdef MULDIV_RADIX4_EN
    acc_nxt = op_q[2] ? div_step(step1, opnd_q) : mul_step(step1, opnd_q);
`else
    acc_nxt = step1;
`endif
    prod    = neg_q ? -acc_q : acc_q;
    div_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (op_q[2])              fix_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d  = op;
          neg_d = (op[2] && op[1]) ? s1 : (s1 ^ s2);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d   = IterM1;
            acc_d   = {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
            opnd_d  = op[2] ? mag2 : mag1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = acc_nxt;
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 5'd1;
      end
      StFix: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign keep   = (((state_q == StIdle) && start) || (state_q == StCalc) ||
                   (state_q == StFix)) && !flush;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M vectors, flush, back-to-back
// and randomized ops against an arithmetic reference model.
module tb_muldiv_seq;

`ifdef MULDIV_RADIX4_EN
  localparam int Lat = 18;
`else
  localparam int Lat = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        keep;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .keep   (keep),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, b);
    return (o[2] && b == 32'h0) ||
           ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Called at a falling edge; leaves start high through the DONE cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, exp_res,
                        input string name);
    int lat;
    int got;
    lat   = is_special(o, a, b) ? 1 : Lat;
    got   = -1;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    flush = 1'b0;
    for (int cyc = 0; cyc < Lat + 10; cyc++) begin
      #1;
      checks++;
      if (keep !== 1'(cyc < lat))
        $display("FAIL %s keep cycle %0d: got %b want %b", name, cyc, keep, cyc < lat);
      else passes++;
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (got != lat) $display("FAIL %s done cycle: got %0d want %0d", name, got, lat);
    else passes++;
    checks++;
    if (result !== exp_res) $display("FAIL %s result: got %h want %h", name, result, exp_res);
    else passes++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      checks++;
      if (keep !== 1'b0 || done !== 1'b0)
        $display("FAIL idle keep/done: got %b/%b want 0/0", keep, done);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    rs1   = 32'h0;
    rs2   = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (keep !== 1'b0) $display("FAIL reset keep: got %b want 0", keep); else passes++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else passes++;
    checks++;
    if (result !== 32'h0) $display("FAIL reset result: got %h want 0", result); else passes++;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_directed();
    @(negedge clk); run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    idle_cycles(2);
    @(negedge clk); run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    idle_cycles(1);
    @(negedge clk); run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    idle_cycles(1);
    @(negedge clk); run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    idle_cycles(1);
    @(negedge clk); run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    idle_cycles(1);
    @(negedge clk); run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    idle_cycles(1);
    @(negedge clk); run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_zero");
    idle_cycles(1);
    @(negedge clk); run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_zero");
    idle_cycles(1);
    @(negedge clk); run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    idle_cycles(1);
    @(negedge clk); run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
    idle_cycles(2);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int dc0;
    prev = result;
    dc0  = done_cnt;
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    rs1   = 32'd1000;
    rs2   = 32'd7;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      checks++;
      if (keep !== 1'b1) $display("FAIL flush pre keep cycle %0d: got %b want 1", cyc, keep);
      else passes++;
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (keep !== 1'b0) $display("FAIL flush keep: got %b want 0", keep); else passes++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (result !== prev) $display("FAIL flush result: got %h want %h", result, prev);
    else passes++;
    checks++;
    if (done_cnt != dc0) $display("FAIL flush done: got %0d want %0d", done_cnt - dc0, 0);
    else passes++;
    // Still in the same cycle (11): the replacement op must be taken from IDLE.
    #(-0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, "flush_mul");
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    int dc0;
    dc0 = done_cnt;
    @(negedge clk); run_op(3'd0, 32'd3, 32'd4, 32'd12, "b2b_first");
    @(negedge clk); run_op(3'd0, 32'd5, 32'd6, 32'd30, "b2b_second");
    idle_cycles(3);
    checks++;
    if (done_cnt - dc0 != 2) $display("FAIL b2b done pulses: got %0d want 2", done_cnt - dc0);
    else passes++;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
      @(negedge clk);
      run_op(o, a, b, ref_model(o, a, b), "random");
    end
    idle_cycles(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the RV32M instructions in the execute stage. It accepts an M-extension operation together with its forwarded operands, raises `keep` on the pipeline while it iterates, and presents the 32-bit result with a one-cycle `done` pulse. The pipeline then advances and the execute stage captures `result` in place of the ALU output. It sits beside the execute ALU; `keep` is OR-ed into the stage `keep`, and `flush` is driven from the branch-miss control.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  valid M-op in EX; held high while `keep` is asserted.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  32  forwarded effective operand 1 (multiplicand/dividend).
- `rs2`  in  32  forwarded effective operand 2 (multiplier/divisor).
- `flush`  in  1  kill the in-flight op (branch miss or exception).
- `keep`  out  1  stall request to IF/ID/EX; combinational.
- `done`  out  1  result valid this cycle; registered one-cycle pulse.
- `result`  out  32  registered result; holds its value until the next completion.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `start`=1 and `flush`=0: latch `op`, operand magnitudes, signs and special-case flags.
  - Divide by zero or signed overflow (0x80000000 / -1): go to DONE.
  - Otherwise: load counter with ITER-1 and go to CALC.
- **CALC:**
  - MUL*: one shift-add step per iteration on a 64-bit product of magnitudes.
  - DIV*/REM*: one restoring shift-subtract step per iteration on the remainder/quotient.
  - Counter reaches 0: go to FIX.
- **FIX:**
  - Apply sign correction: negate the product if the operand signs differ; quotient sign = sign(rs1) XOR sign(rs2); remainder takes the sign of rs1.
  - Select the high or low product word, or quotient vs remainder.
  - Write `result`, go to DONE.
- **DONE:**
  - `done`=1, `keep`=0, go to IDLE unconditionally.
  - `start` seen in DONE is the same instruction and is ignored.
- **Sign handling:** MULHSU treats rs1 as signed and rs2 as unsigned; the unsigned ops use raw operands.
- **Special results:**
  - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1.
  - Signed overflow: quotient 0x80000000, remainder 0.
- **keep** = ((IDLE & `start`) | CALC | FIX) & !`flush`.
- **flush** or **rst** in any state: IDLE next cycle; no `done`; `result` unchanged.
- **Reset values:** state IDLE, `keep`=0, `done`=0, `result`=0, counter 0.

## Timing
- `start` sampled at edge 0 (IDLE); ITER=32.
  - CALC occupies cycles 1..32.
  - FIX in cycle 33.
  - DONE in cycle 34 (`done`=1, `keep`=0).
  - The EX register captures `result` at the end of cycle 34.
- `keep` is high from cycle 0 through cycle 33 inclusive.
- Special cases: DONE in cycle 1; `keep` high only in cycle 0.
- Back-to-back ops: the next M-op reaches EX in cycle 35 while in IDLE and starts with no bubble.
- `flush` in cycle k: `keep`=0 in cycle k; IDLE in cycle k+1.
- `flush` coinciding with DONE: `done` still pulses (already registered); the pipeline discards it.

## Configuration
- `MULDIV_RADIX4_EN` defined:
  - Each CALC cycle retires 2 bits; ITER=16.
  - Normal latency: DONE in cycle 18.
  - Special-case latency is unchanged.
- Undefined: radix-2, 1 bit per cycle, DONE in cycle 34.
- Results are bit-identical in both builds.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD -> `result`=0xFFFFFFEB.
  - `done` in cycle 34 (18 with `MULDIV_RADIX4_EN`); `keep` high cycles 0..33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with `done` in cycle 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIV started, `flush` in cycle 10:
  - `keep`=0 in cycle 10; IDLE in cycle 11; no `done`.
  - `result` keeps its previous value.
  - A new MUL 3×4 started in cycle 11 -> 12.
- Two MULs back-to-back (3×4, then 5×6):
  - Results 12 and 30.
  - Second `start` accepted in the cycle after DONE; `done` pulses exactly twice.
